// File: rtl/mips_pkg.sv
// Shared definitions for the ROM fetch path.
// Holds default widths, the NOP encoding and the grant-source enum.
package mips_pkg;

    localparam int DEF_ADDR_W   = 31;
    localparam int DEF_DATA_W   = 32;
    localparam int STARVE_CNT_W = 4;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_IF,
        GNT_DBG,
        GNT_FORCE
    } grant_e;

endpackage

// File: rtl/rom_starve_counter.sv
// Counts consecutive denied debug cycles and raises force_dbg so that
// debug is granted exactly STARVE_LIMIT denied cycles after it asks.
// Ports: clk, reset (async, active-high), dbg_req, dbg_granted in;
//        force_dbg out (registered).
module rom_starve_counter
    import mips_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic dbg_req,
    input  logic dbg_granted,
    output logic force_dbg
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT =
        STARVE_CNT_W'(STARVE_LIMIT);
    localparam logic [STARVE_CNT_W-1:0] LIMIT_M1 =
        STARVE_CNT_W'(STARVE_LIMIT - 1);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;
    logic                    force_q;
    logic                    force_d;

    always_comb begin
        cnt_d   = '0;
        force_d = 1'b0;
        if (dbg_req && !dbg_granted) begin
            // Saturate so a long denial cannot wrap back to zero.
            if (cnt_q < LIMIT) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q;
            end
            force_d = (cnt_q >= LIMIT_M1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            force_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            force_q <= force_d;
        end
    end

    assign force_dbg = force_q;

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Arbitrates the single-ported combinational ROM between IF (priority,
// same-cycle data) and a debug read port with a registered response.
// Ports: clk, reset; if_req/if_addr/if_data/if_stall (IF side);
//        dbg_req/dbg_addr/dbg_ready/dbg_rvalid/dbg_rdata (debug side);
//        rom_addr/rom_data (ROM side).
module rom_fetch_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_data,
    output logic              if_stall,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_ready,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    grant_e            grant_sel;
    logic              force_dbg;
    logic              rvalid_q;
    logic              rvalid_d;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    rom_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .dbg_req    (dbg_req),
        .dbg_granted(dbg_ready),
        .force_dbg  (force_dbg)
    );

    // Reset is decoded combinationally so no grant leaks out while
    // the block is held in reset.
    always_comb begin
        grant_sel = GNT_IDLE;
        if (reset) begin
            grant_sel = GNT_IDLE;
        end else if (force_dbg && dbg_req) begin
            grant_sel = GNT_FORCE;
        end else if (if_req) begin
            grant_sel = GNT_IF;
        end else if (dbg_req) begin
            grant_sel = GNT_DBG;
        end
    end

    always_comb begin
        rom_addr  = if_addr;
        if_data   = rom_data;
        if_stall  = 1'b0;
        dbg_ready = 1'b0;
        unique case (grant_sel)
            GNT_FORCE: begin
                rom_addr  = dbg_addr;
                if_data   = DATA_W'(NOP_INSTR);
                if_stall  = if_req;
                dbg_ready = 1'b1;
            end
            GNT_DBG: begin
                rom_addr  = dbg_addr;
                dbg_ready = 1'b1;
            end
            GNT_IF, GNT_IDLE: begin
                rom_addr = if_addr;
            end
        endcase
    end

    always_comb begin
        rvalid_d = dbg_ready;
        rdata_d  = rdata_q;
        if (dbg_ready) begin
            rdata_d = rom_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign dbg_rvalid = rvalid_q;
    assign dbg_rdata  = rdata_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Scoreboard bench for rom_fetch_arbiter with a behavioural ROM.
// Directed stimulus pushes expected debug data; a monitor pops it.
module tb_rom_fetch_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [30:0] if_addr;
    logic [31:0] if_data;
    logic        if_stall;
    logic        dbg_req;
    logic [30:0] dbg_addr;
    logic        dbg_ready;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic [30:0] rom_addr;
    logic [31:0] rom_data;

    int checks = 0;
    int failures = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_read(input logic [30:0] a);
        if (a >= 31'h400) return 32'h0;
        case (a[9:2])
            8'd5:    return 32'h3c11_4000;
            8'd6:    return 32'h2631_0004;
            8'd7:    return 32'h2410_00aa;
            8'd8:    return 32'hae20_0000;
            8'd9:    return 32'h0810_0000;
            default: return {24'hA5A5A5, a[9:2]};
        endcase
    endfunction

    assign rom_data = rom_read(rom_addr);

    rom_fetch_arbiter #(
        .ADDR_W(31),
        .DATA_W(32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_data   (if_data),
        .if_stall  (if_stall),
        .dbg_req   (dbg_req),
        .dbg_addr  (dbg_addr),
        .dbg_ready (dbg_ready),
        .dbg_rvalid(dbg_rvalid),
        .dbg_rdata (dbg_rdata),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data)
    );

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response pulse must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (dbg_rvalid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL rvalid_unexpected: data %h", dbg_rdata);
                end else begin
                    logic [31:0] e;
                    e = sb.pop_front();
                    if (dbg_rdata !== e) begin
                        failures++;
                        $display("FAIL rdata: got %h expected %h",
                                 dbg_rdata, e);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        if_req   = 1'b0;
        if_addr  = 31'h14;
        dbg_req  = 1'b1;
        dbg_addr = 31'h18;
        #2;
        chk("rst_ready", 32'(dbg_ready), 32'd0);
        chk("rst_stall", 32'(if_stall), 32'd0);
        chk("rst_romaddr", 32'(rom_addr), 32'h14);
        chk("rst_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("rst_rdata", dbg_rdata, 32'h0);
        dbg_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // IF only
        reset   = 1'b0;
        if_req  = 1'b1;
        if_addr = 31'h14;
        #1;
        chk("if_data", if_data, 32'h3c11_4000);
        chk("if_stall", 32'(if_stall), 32'd0);
        chk("if_romaddr", 32'(rom_addr), 32'h14);
        step();
        if_addr = 31'h18;
        #1;
        chk("if_data2", if_data, 32'h2631_0004);

        // Debug on idle bus
        step();
        if_req   = 1'b0;
        dbg_req  = 1'b1;
        dbg_addr = 31'h18;
        #1;
        chk("idle_ready", 32'(dbg_ready), 32'd1);
        chk("idle_stall", 32'(if_stall), 32'd0);
        sb.push_back(32'h2631_0004);
        step();
        dbg_req = 1'b0;
        step();

        // Starvation with IF held busy
        if_req   = 1'b1;
        dbg_req  = 1'b1;
        dbg_addr = 31'h1C;
        for (int k = 0; k < 4; k++) begin
            if_addr = 31'h100 + 31'(4 * k);
            #1;
            chk("starve_ready", 32'(dbg_ready), 32'd0);
            chk("starve_stall", 32'(if_stall), 32'd0);
            chk("starve_ifdata", if_data, rom_read(if_addr));
            step();
        end
        if_addr = 31'h110;
        #1;
        chk("force_ready", 32'(dbg_ready), 32'd1);
        chk("force_stall", 32'(if_stall), 32'd1);
        chk("force_ifdata", if_data, 32'h0);
        chk("force_romaddr", 32'(rom_addr), 32'h1C);
        sb.push_back(32'h2410_00aa);
        step();
        dbg_req = 1'b0;
        #1;
        chk("post_stall", 32'(if_stall), 32'd0);
        chk("post_ifdata", if_data, rom_read(31'h110));
        step();
        if_req = 1'b0;

        // Back-to-back debug reads
        dbg_req  = 1'b1;
        dbg_addr = 31'h20;
        #1;
        chk("b2b_ready0", 32'(dbg_ready), 32'd1);
        sb.push_back(32'hae20_0000);
        step();
        dbg_addr = 31'h24;
        #1;
        chk("b2b_ready1", 32'(dbg_ready), 32'd1);
        chk("b2b_rvalid", 32'(dbg_rvalid), 32'd1);
        sb.push_back(32'h0810_0000);
        step();
        chk("b2b_rvalid2", 32'(dbg_rvalid), 32'd1);

        // Out of range
        dbg_addr = 31'h400;
        #1;
        chk("oor_ready", 32'(dbg_ready), 32'd1);
        sb.push_back(32'h0);
        step();
        dbg_req = 1'b0;
        step();
        chk("hold_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("hold_rdata", dbg_rdata, 32'h0);

        // Reset in the cycle after a debug accept
        dbg_req  = 1'b1;
        dbg_addr = 31'h18;
        #1;
        sb.push_back(32'h2631_0004);
        step();
        chk("pre_rst_rvalid", 32'(dbg_rvalid), 32'd1);
        if_req   = 1'b1;
        if_addr  = 31'h200;
        dbg_addr = 31'h1C;
        reset    = 1'b1;
        #1;
        chk("mid_rst_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("mid_rst_cnt", 32'(dut.u_starve.cnt_q), 32'd0);
        chk("mid_rst_ready", 32'(dbg_ready), 32'd0);
        chk("mid_rst_stall", 32'(if_stall), 32'd0);
        sb.delete();
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rst_starve_ready", 32'(dbg_ready), 32'd0);
            step();
        end
        #1;
        chk("rst_force_ready", 32'(dbg_ready), 32'd1);
        chk("rst_force_stall", 32'(if_stall), 32'd1);
        sb.push_back(32'h2410_00aa);
        step();
        dbg_req = 1'b0;
        #1;
        chk("rst_post_stall", 32'(if_stall), 32'd0);
        step();
        if_req = 1'b0;
        repeat (3) step();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
